mgmt_bus_arbiter: RTL and testbench
===================================

// Module: mgmt_bus_arbiter
// PURPOSE
//  Parametrised N-master arbiter for the byte-wide management register bus (rd_en/rd_addr/rd_valid/rd_data,
//  wr_en/wr_addr/wr_data). Lets several bus masters (MCU bridge, debug bridge, internal sequencers) share one
//  register interface. Arbitration is round-robin, with one outstanding transaction per master and an optional
//  read timeout. Sits between the masters and the management register interface in the clk_ram_ctl domain.
// PARAMETERS
//  NUM_MASTERS     2    number of requesting masters (>=1)
//  ADDR_WIDTH      16   register address width
//  DATA_WIDTH      8    register data width
//  TIMEOUT_CYCLES  255  read-response timeout in clk cycles (used only with MGMT_ARB_TIMEOUT_EN)
// PORTS
//  clk        in   1                       management clock
//  rst        in   1                       asynchronous active-high reset
//  m_rd_en    in   NUM_MASTERS             per-master read request pulse
//  m_wr_en    in   NUM_MASTERS             per-master write request pulse
//  m_addr     in   NUM_MASTERS*ADDR_WIDTH  per-master address (master i at [i*AW +: AW]), sampled with the request
//  m_wr_data  in   NUM_MASTERS*DATA_WIDTH  per-master write data, sampled with m_wr_en
//  m_rd_valid out  NUM_MASTERS             per-master read completion pulse
//  m_rd_data  out  DATA_WIDTH              read data, valid while any m_rd_valid bit is high
//  m_rd_err   out  NUM_MASTERS             read timed out (pulses together with m_rd_valid)
//  m_wr_done  out  NUM_MASTERS             write issued downstream (one-cycle pulse)
//  s_rd_en    out  1                       downstream read strobe
//  s_wr_en    out  1                       downstream write strobe
//  s_addr     out  ADDR_WIDTH              downstream address
//  s_wr_data  out  DATA_WIDTH              downstream write data
//  s_rd_valid in   1                       downstream read response strobe
//  s_rd_data  in   DATA_WIDTH              downstream read data
// BEHAVIOUR
//  - Interface: one clock (clk), reset rst is asynchronous and active-high. On reset, all outputs are 0,
//    all pending registers are cleared, state is IDLE, and last_grant = NUM_MASTERS-1 (master 0 wins first).
//  - Request capture: a pulse on m_rd_en[i] or m_wr_en[i] latches {type, addr, data} into pending slot i.
//    Requests arriving while slot i is already pending are dropped. If rd_en and wr_en are high together,
//    the write is captured and the read is dropped.
//  - Arbitration happens in IDLE only. The arbiter searches for a pending slot starting at
//    (last_grant+1) mod NUM_MASTERS and grants the first one found. Granting updates last_grant and clears the slot.
//  - All outputs are registered. With the bus idle, a request pulse in cycle 0 gives s_*_en high in cycle 2.
//    Strobes are exactly one cycle wide. s_addr/s_wr_data hold their value until the next grant.
//  - Write grant: s_wr_en and m_wr_done[g] pulse in the same cycle; state stays IDLE. Writes from different
//    masters can therefore issue on consecutive cycles.
//  - Read grant: s_rd_en pulses, then state moves to RD_WAIT. s_rd_valid in cycle k gives m_rd_valid[g] in
//    cycle k+1, with m_rd_data = s_rd_data registered at k. State then returns to IDLE; the next grant is at
//    the earliest in cycle k+1.
//  - s_rd_valid while in IDLE, or arriving in the same cycle as the s_rd_en issue, is ignored.
//  - m_rd_data holds its last value between completions.
//  - States: IDLE -(read grant)-> RD_WAIT -(s_rd_valid | timeout)-> IDLE.
//  - Reset mid-read: the transaction is abandoned and no m_rd_valid is produced. A late s_rd_valid is ignored.
//  - NUM_MASTERS=1: arbitration degenerates to a pass-through with the same latency.
// CONFIGURATION
//  MGMT_ARB_TIMEOUT_EN defined:
//  - A counter of width $clog2(TIMEOUT_CYCLES+1) clears on entry to RD_WAIT and increments each RD_WAIT cycle.
//  - When it reaches TIMEOUT_CYCLES with no s_rd_valid, the next cycle pulses m_rd_valid[g] and m_rd_err[g],
//    with m_rd_data = all-ones, and state returns to IDLE.
//  - If s_rd_valid coincides with the terminal count, normal completion wins and m_rd_err stays 0.
//  MGMT_ARB_TIMEOUT_EN undefined:
//  - No counter; RD_WAIT waits indefinitely and m_rd_err is tied to 0.
// TESTING
//  1. NUM_MASTERS=2, m_wr_en[0] cycle 0, addr 0x0010, data 0xA5
//     -> s_wr_en + m_wr_done[0] in cycle 2, s_addr=0x0010, s_wr_data=0xA5.
//  2. Both masters read (addrs 0x0100 / 0x0200) in the same cycle; slave returns 0x11 then 0x22
//     -> master 0 is served first, m_rd_valid[0] with 0x11, then master 1 with 0x22;
//     a repeated contention then grants master 1 first.
//  3. m_rd_en[1] pulsed twice while pending
//     -> exactly one s_rd_en and one m_rd_valid[1]; the second request is dropped.
//  4. Stray s_rd_valid (data 0x77) in IDLE -> no m_rd_valid; state stays IDLE.
//  5. With MGMT_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8, slave silent
//     -> m_rd_valid[0] + m_rd_err[0], data 0xFF, 10 cycles after s_rd_en.
//     Rerun without the macro: no completion after 1000 cycles.
//  6. rst asserted in RD_WAIT, then the slave responds -> all outputs 0; no m_rd_valid; next request served normally.

Source files
------------

// File: rtl/mgmt_bus_arbiter.sv
// Round-robin N-master arbiter for the byte-wide management register bus.
// Optional read-response timeout is enabled by defining MGMT_ARB_TIMEOUT_EN.
module mgmt_bus_arbiter #(
  parameter int NUM_MASTERS    = 2,
  parameter int ADDR_WIDTH     = 16,
  parameter int DATA_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_MASTERS-1:0]            m_rd_en,
  input  logic [NUM_MASTERS-1:0]            m_wr_en,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_addr,
  input  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_wr_data,
  output logic [NUM_MASTERS-1:0]            m_rd_valid,
  output logic [DATA_WIDTH-1:0]             m_rd_data,
  output logic [NUM_MASTERS-1:0]            m_rd_err,
  output logic [NUM_MASTERS-1:0]            m_wr_done,
  output logic                              s_rd_en,
  output logic                              s_wr_en,
  output logic [ADDR_WIDTH-1:0]             s_addr,
  output logic [DATA_WIDTH-1:0]             s_wr_data,
  input  logic                              s_rd_valid,
  input  logic [DATA_WIDTH-1:0]             s_rd_data
);

  localparam int LGW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

  typedef enum logic {IDLE, RD_WAIT} state_t;

  state_t                  r_state, w_stateNext;
  logic [NUM_MASTERS-1:0]  r_pendValid, r_pendWrite;
  logic [ADDR_WIDTH-1:0]   r_pendAddr [NUM_MASTERS];
  logic [DATA_WIDTH-1:0]   r_pendData [NUM_MASTERS];
  logic [LGW-1:0]          r_lastGrant, r_rdOwner;
  logic [LGW-1:0]          w_grantIdx, w_slotIdx;
  logic                    w_grant, w_grantWrite, w_rdDone, w_rdTimeout;
  int                      w_slot;

  logic                    r_sRdEn, r_sWrEn;
  logic [ADDR_WIDTH-1:0]   r_sAddr;
  logic [DATA_WIDTH-1:0]   r_sWrData;
  logic [NUM_MASTERS-1:0]  r_mRdValid, r_mWrDone;
  logic [DATA_WIDTH-1:0]   r_mRdData;

`ifdef MGMT_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0]           r_toCnt;
  logic [NUM_MASTERS-1:0]  r_mRdErr;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_stateNext;
  end

  // Search starts one past the last winner; a response in the issue cycle is not accepted.
  always_comb begin
    w_stateNext  = r_state;
    w_grant      = 1'b0;
    w_grantIdx   = '0;
    w_grantWrite = 1'b0;
    w_rdDone     = 1'b0;
    w_rdTimeout  = 1'b0;
    w_slot       = 0;
    w_slotIdx    = '0;
    case (r_state)
      IDLE: begin
        for (int k = 1; k <= NUM_MASTERS; k++) begin
          w_slot    = (int'(r_lastGrant) + k) % NUM_MASTERS;
          w_slotIdx = LGW'(w_slot);
          if (!w_grant && r_pendValid[w_slotIdx]) begin
            w_grant      = 1'b1;
            w_grantIdx   = w_slotIdx;
            w_grantWrite = r_pendWrite[w_slotIdx];
          end
        end
        if (w_grant && !w_grantWrite) w_stateNext = RD_WAIT;
      end
      RD_WAIT: begin
        if (s_rd_valid && !r_sRdEn) begin
          w_rdDone    = 1'b1;
          w_stateNext = IDLE;
        end
`ifdef MGMT_ARB_TIMEOUT_EN
        else if (!r_sRdEn && r_toCnt == CW'(TIMEOUT_CYCLES)) begin
          w_rdTimeout = 1'b1;
          w_stateNext = IDLE;
        end
`endif
      end
      default: w_stateNext = IDLE;
    endcase
  end

  // A slot only accepts a request while empty; write wins over a simultaneous read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pendValid <= '0;
      r_pendWrite <= '0;
      for (int i = 0; i < NUM_MASTERS; i++) begin
        r_pendAddr[i] <= '0;
        r_pendData[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_MASTERS; i++) begin
        if (w_grant && w_grantIdx == LGW'(i)) begin
          r_pendValid[i] <= 1'b0;
        end else if (!r_pendValid[i] && (m_rd_en[i] || m_wr_en[i])) begin
          r_pendValid[i] <= 1'b1;
          r_pendWrite[i] <= m_wr_en[i];
          r_pendAddr[i]  <= m_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
          r_pendData[i]  <= m_wr_data[i*DATA_WIDTH +: DATA_WIDTH];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lastGrant <= LGW'(NUM_MASTERS - 1);
      r_rdOwner   <= '0;
      r_sRdEn     <= 1'b0;
      r_sWrEn     <= 1'b0;
      r_sAddr     <= '0;
      r_sWrData   <= '0;
      r_mRdValid  <= '0;
      r_mWrDone   <= '0;
      r_mRdData   <= '0;
`ifdef MGMT_ARB_TIMEOUT_EN
      r_mRdErr    <= '0;
`endif
    end else begin
      r_sRdEn    <= 1'b0;
      r_sWrEn    <= 1'b0;
      r_mRdValid <= '0;
      r_mWrDone  <= '0;
`ifdef MGMT_ARB_TIMEOUT_EN
      r_mRdErr   <= '0;
`endif
      if (w_grant) begin
        r_lastGrant <= w_grantIdx;
        r_sAddr     <= r_pendAddr[w_grantIdx];
        if (w_grantWrite) begin
          r_sWrEn               <= 1'b1;
          r_sWrData             <= r_pendData[w_grantIdx];
          r_mWrDone[w_grantIdx] <= 1'b1;
        end else begin
          r_sRdEn   <= 1'b1;
          r_rdOwner <= w_grantIdx;
        end
      end
      if (w_rdDone) begin
        r_mRdValid[r_rdOwner] <= 1'b1;
        r_mRdData             <= s_rd_data;
      end
`ifdef MGMT_ARB_TIMEOUT_EN
      if (w_rdTimeout) begin
        r_mRdValid[r_rdOwner] <= 1'b1;
        r_mRdErr[r_rdOwner]   <= 1'b1;
        r_mRdData             <= '1;
      end
`endif
    end
  end

`ifdef MGMT_ARB_TIMEOUT_EN
  // The issue cycle is not counted, so the error surfaces TIMEOUT_CYCLES+2 cycles after s_rd_en.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                r_toCnt <= '0;
    else if (w_grant && !w_grantWrite)      r_toCnt <= '0;
    else if (r_state == RD_WAIT && !r_sRdEn) r_toCnt <= r_toCnt + 1'b1;
  end
  assign m_rd_err = r_mRdErr;
`else
  assign m_rd_err = '0;
`endif

  assign s_rd_en    = r_sRdEn;
  assign s_wr_en    = r_sWrEn;
  assign s_addr     = r_sAddr;
  assign s_wr_data  = r_sWrData;
  assign m_rd_valid = r_mRdValid;
  assign m_rd_data  = r_mRdData;
  assign m_wr_done  = r_mWrDone;

endmodule

// File: tb/tb_mgmt_bus_arbiter.sv
// Self-checking bench for mgmt_bus_arbiter: vector table for writes, scoreboard of timed bus events,
// and hand sequences for contention, drops, stray responses, timeout and reset mid-read.
module tb_mgmt_bus_arbiter;

  localparam int NM = 2;
  localparam int AW = 16;
  localparam int DW = 8;
  localparam int TO = 8;
  localparam int KWR = 0;
  localparam int KRD = 1;
  localparam int KCMP = 2;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [NM-1:0]    m_rd_en = '0;
  logic [NM-1:0]    m_wr_en = '0;
  logic [NM*AW-1:0] m_addr = '0;
  logic [NM*DW-1:0] m_wr_data = '0;
  logic [NM-1:0]    m_rd_valid, m_rd_err, m_wr_done;
  logic [DW-1:0]    m_rd_data;
  logic             s_rd_en, s_wr_en;
  logic [AW-1:0]    s_addr;
  logic [DW-1:0]    s_wr_data;
  logic             s_rd_valid = 1'b0;
  logic [DW-1:0]    s_rd_data = '0;

  mgmt_bus_arbiter #(
    .NUM_MASTERS(NM), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst(rst),
    .m_rd_en(m_rd_en), .m_wr_en(m_wr_en), .m_addr(m_addr), .m_wr_data(m_wr_data),
    .m_rd_valid(m_rd_valid), .m_rd_data(m_rd_data), .m_rd_err(m_rd_err), .m_wr_done(m_wr_done),
    .s_rd_en(s_rd_en), .s_wr_en(s_wr_en), .s_addr(s_addr), .s_wr_data(s_wr_data),
    .s_rd_valid(s_rd_valid), .s_rd_data(s_rd_data)
  );

  initial forever #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cycle;
    int          kind;
    int          master;
    logic [15:0] addr;
    logic [7:0]  data;
    logic        err;
  } ev_t;

  typedef struct {
    int          master;
    logic        rd;
    logic        wr;
    logic [15:0] addr;
    logic [7:0]  data;
    logic [15:0] expAddr;
    logic [7:0]  expData;
  } vec_t;

  ev_t  sbq[$];
  vec_t vecs[5];
  int   nTests = 0;
  int   nFail = 0;
  int   rdValidSeen = 0;
  int   base;
  int   snap;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  function automatic logic [NM-1:0] bitOf(input int m);
    logic [NM-1:0] v;
    v = '0;
    v[m] = 1'b1;
    return v;
  endfunction

  task automatic expectEv(input int c, input int k, input int m, input logic [15:0] a,
                          input logic [7:0] d, input logic e);
    ev_t ev;
    ev.cycle = c; ev.kind = k; ev.master = m; ev.addr = a; ev.data = d; ev.err = e;
    sbq.push_back(ev);
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nTests++;
    if (act !== exp) begin
      nFail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Compares any bus activity this cycle against the head of the scoreboard.
  task automatic monitorStep();
    ev_t e;
    logic ok;
    logic [NM-1:0] eDone, eValid, eErr;
    if (rst) return;
    while (sbq.size() > 0 && sbq[0].cycle < cyc) begin
      nTests++;
      nFail++;
      $display("[TB] FAIL missed_event kind=%0d master=%0d: nothing seen, expected at cycle %0d (now %0d)",
               sbq[0].kind, sbq[0].master, sbq[0].cycle, cyc);
      void'(sbq.pop_front());
    end
    if (s_wr_en || s_rd_en || (|m_rd_valid) || (|m_wr_done) || (|m_rd_err)) begin
      if (|m_rd_valid) rdValidSeen++;
      nTests++;
      if (sbq.size() == 0) begin
        nFail++;
        $display("[TB] FAIL unexpected_event cyc=%0d: got wr=%b rd=%b done=%b valid=%b err=%b, expected no activity",
                 cyc, s_wr_en, s_rd_en, m_wr_done, m_rd_valid, m_rd_err);
      end else begin
        e = sbq.pop_front();
        eDone  = (e.kind == KWR) ? bitOf(e.master) : '0;
        eValid = (e.kind == KCMP) ? bitOf(e.master) : '0;
        eErr   = (e.kind == KCMP && e.err) ? bitOf(e.master) : '0;
        ok = (cyc == e.cycle) && (s_wr_en === (e.kind == KWR)) && (s_rd_en === (e.kind == KRD)) &&
             (m_wr_done === eDone) && (m_rd_valid === eValid) && (m_rd_err === eErr);
        if (e.kind != KCMP) ok = ok && (s_addr === e.addr);
        if (e.kind == KWR)  ok = ok && (s_wr_data === e.data);
        if (e.kind == KCMP) ok = ok && (m_rd_data === e.data);
        if (!ok) begin
          nFail++;
          $display("[TB] FAIL event kind=%0d m=%0d: got cyc=%0d wr=%b rd=%b done=%b valid=%b err=%b addr=%h wdata=%h rdata=%h; expected cyc=%0d addr=%h data=%h err=%b",
                   e.kind, e.master, cyc, s_wr_en, s_rd_en, m_wr_done, m_rd_valid, m_rd_err,
                   s_addr, s_wr_data, m_rd_data, e.cycle, e.addr, e.data, e.err);
        end
      end
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      monitorStep();
    end
  endtask

  task automatic applyStimulus(input int m, input logic rd, input logic wr,
                               input logic [15:0] addr, input logic [7:0] data);
    m_rd_en[m] = rd;
    m_wr_en[m] = wr;
    m_addr[m*AW +: AW] = addr;
    m_wr_data[m*DW +: DW] = data;
  endtask

  task automatic clearReq();
    m_rd_en = '0;
    m_wr_en = '0;
  endtask

  task automatic slave(input logic v, input logic [7:0] d);
    s_rd_valid = v;
    s_rd_data = d;
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_s_rd_en"},    32'(s_rd_en), 0);
    checkOutput({tag, "_s_wr_en"},    32'(s_wr_en), 0);
    checkOutput({tag, "_s_addr"},     32'(s_addr), 0);
    checkOutput({tag, "_s_wr_data"},  32'(s_wr_data), 0);
    checkOutput({tag, "_m_rd_valid"}, 32'(m_rd_valid), 0);
    checkOutput({tag, "_m_rd_data"},  32'(m_rd_data), 0);
    checkOutput({tag, "_m_rd_err"},   32'(m_rd_err), 0);
    checkOutput({tag, "_m_wr_done"},  32'(m_wr_done), 0);
  endtask

  initial begin
    vecs[0] = '{0, 1'b0, 1'b1, 16'h0010, 8'hA5, 16'h0010, 8'hA5};
    vecs[1] = '{1, 1'b0, 1'b1, 16'h1234, 8'h5A, 16'h1234, 8'h5A};
    vecs[2] = '{0, 1'b1, 1'b1, 16'hFFFF, 8'h00, 16'hFFFF, 8'h00};
    vecs[3] = '{1, 1'b1, 1'b1, 16'h8001, 8'hC3, 16'h8001, 8'hC3};
    vecs[4] = '{1, 1'b0, 1'b1, 16'h0000, 8'hFF, 16'h0000, 8'hFF};

    tick(2);
    checkAllZero("reset");
    rst = 1'b0;
    tick(1);

    // Single-master writes (rd+wr together must issue as a write), two cycles of latency.
    for (int i = 0; i < 5; i++) begin
      tick(1);
      base = cyc;
      expectEv(base + 2, KWR, vecs[i].master, vecs[i].expAddr, vecs[i].expData, 1'b0);
      applyStimulus(vecs[i].master, vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].data);
      tick(1);
      clearReq();
      tick(3);
    end
    checkOutput("table_sbq_empty", 32'(sbq.size()), 0);

    // Both masters write together: back-to-back issue, master 0 first after master 1 won last.
    tick(1);
    base = cyc;
    expectEv(base + 2, KWR, 0, 16'h0101, 8'h01, 1'b0);
    expectEv(base + 3, KWR, 1, 16'h0202, 8'h02, 1'b0);
    applyStimulus(0, 1'b0, 1'b1, 16'h0101, 8'h01);
    applyStimulus(1, 1'b0, 1'b1, 16'h0202, 8'h02);
    tick(1);
    clearReq();
    tick(4);
    checkOutput("dual_wr_sbq_empty", 32'(sbq.size()), 0);

    // Read contention, response ignored in issue cycle, then rotation favours master 1.
    tick(1);
    base = cyc;
    expectEv(base + 2,  KRD,  0, 16'h0100, 8'h00, 1'b0);
    expectEv(base + 5,  KCMP, 0, 16'h0000, 8'h11, 1'b0);
    expectEv(base + 6,  KRD,  1, 16'h0200, 8'h00, 1'b0);
    expectEv(base + 9,  KCMP, 1, 16'h0000, 8'h22, 1'b0);
    expectEv(base + 10, KRD,  0, 16'h0300, 8'h00, 1'b0);
    expectEv(base + 13, KCMP, 0, 16'h0000, 8'h33, 1'b0);
    applyStimulus(0, 1'b1, 1'b0, 16'h0100, 8'h00);
    applyStimulus(1, 1'b1, 1'b0, 16'h0200, 8'h00);
    tick(1);
    clearReq();
    tick(1);
    slave(1'b1, 8'h55);
    tick(1);
    slave(1'b0, 8'h00);
    applyStimulus(0, 1'b1, 1'b0, 16'h0300, 8'h00);
    applyStimulus(1, 1'b1, 1'b0, 16'h0999, 8'h00);
    tick(1);
    clearReq();
    slave(1'b1, 8'h11);
    tick(1);
    slave(1'b0, 8'h00);
    tick(3);
    slave(1'b1, 8'h22);
    tick(1);
    slave(1'b0, 8'h00);
    tick(3);
    slave(1'b1, 8'h33);
    tick(1);
    slave(1'b0, 8'h00);
    tick(4);
    checkOutput("contention_sbq_empty", 32'(sbq.size()), 0);

    // Second read pulse while the slot is pending is dropped.
    tick(1);
    base = cyc;
    expectEv(base + 2, KRD,  1, 16'h0A0A, 8'h00, 1'b0);
    expectEv(base + 5, KCMP, 1, 16'h0000, 8'h44, 1'b0);
    applyStimulus(1, 1'b1, 1'b0, 16'h0A0A, 8'h00);
    tick(1);
    applyStimulus(1, 1'b1, 1'b0, 16'h0B0B, 8'h00);
    tick(1);
    clearReq();
    tick(2);
    slave(1'b1, 8'h44);
    tick(1);
    slave(1'b0, 8'h00);
    tick(6);
    checkOutput("drop_sbq_empty", 32'(sbq.size()), 0);

    // Stray response in IDLE: no completion, read data holds, bus still idle.
    tick(1);
    snap = rdValidSeen;
    slave(1'b1, 8'h77);
    tick(1);
    slave(1'b0, 8'h00);
    tick(3);
    checkOutput("stray_no_valid", 32'(rdValidSeen - snap), 0);
    checkOutput("rd_data_hold", 32'(m_rd_data), 32'h44);
    tick(1);
    base = cyc;
    expectEv(base + 2, KWR, 0, 16'h0777, 8'h77, 1'b0);
    applyStimulus(0, 1'b0, 1'b1, 16'h0777, 8'h77);
    tick(1);
    clearReq();
    tick(3);
    checkOutput("stray_sbq_empty", 32'(sbq.size()), 0);

`ifdef MGMT_ARB_TIMEOUT_EN
    // Silent slave: error completion with all-ones data 10 cycles after the read strobe.
    tick(1);
    base = cyc;
    expectEv(base + 2,  KRD,  0, 16'h0042, 8'h00, 1'b0);
    expectEv(base + 12, KCMP, 0, 16'h0000, 8'hFF, 1'b1);
    applyStimulus(0, 1'b1, 1'b0, 16'h0042, 8'h00);
    tick(1);
    clearReq();
    tick(14);
    checkOutput("timeout_sbq_empty", 32'(sbq.size()), 0);

    // Response on the terminal count completes normally.
    tick(1);
    base = cyc;
    expectEv(base + 2,  KRD,  1, 16'h0043, 8'h00, 1'b0);
    expectEv(base + 12, KCMP, 1, 16'h0000, 8'h3C, 1'b0);
    applyStimulus(1, 1'b1, 1'b0, 16'h0043, 8'h00);
    tick(1);
    clearReq();
    tick(10);
    slave(1'b1, 8'h3C);
    tick(1);
    slave(1'b0, 8'h00);
    tick(3);
    checkOutput("terminal_sbq_empty", 32'(sbq.size()), 0);

    tick(1);
    base = cyc;
    expectEv(base + 2, KRD, 1, 16'h0055, 8'h00, 1'b0);
    applyStimulus(1, 1'b1, 1'b0, 16'h0055, 8'h00);
    tick(1);
    clearReq();
    tick(2);
`else
    // Without the timeout a silent slave keeps the read outstanding indefinitely.
    tick(1);
    base = cyc;
    snap = rdValidSeen;
    expectEv(base + 2, KRD, 0, 16'h0042, 8'h00, 1'b0);
    applyStimulus(0, 1'b1, 1'b0, 16'h0042, 8'h00);
    tick(1);
    clearReq();
    tick(1000);
    checkOutput("no_timeout_completion", 32'(rdValidSeen - snap), 0);
    checkOutput("no_timeout_sbq_empty", 32'(sbq.size()), 0);
`endif

    // Reset while a read is outstanding; the late response must be ignored.
    tick(1);
    rst = 1'b1;
    tick(1);
    checkAllZero("midread_reset");
    rst = 1'b0;
    snap = rdValidSeen;
    tick(1);
    slave(1'b1, 8'h99);
    tick(1);
    slave(1'b0, 8'h00);
    tick(3);
    checkOutput("late_resp_ignored", 32'(rdValidSeen - snap), 0);
    tick(1);
    base = cyc;
    expectEv(base + 2, KRD,  0, 16'h0066, 8'h00, 1'b0);
    expectEv(base + 5, KCMP, 0, 16'h0000, 8'hC3, 1'b0);
    applyStimulus(0, 1'b1, 1'b0, 16'h0066, 8'h00);
    tick(1);
    clearReq();
    tick(3);
    slave(1'b1, 8'hC3);
    tick(1);
    slave(1'b0, 8'h00);
    tick(4);
    checkOutput("final_sbq_empty", 32'(sbq.size()), 0);

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
